sobel_threshold_ctrl: RTL and testbench

Consumes the debounced one-shot key events from the key debouncer and maintains the Sobel edge-detection gradient threshold. Key presses edit a shadow threshold immediately; the shadow value is committed to the live `threshold` output only at the next frame-start (rising edge of `frame_vsync`), so the threshold never changes mid-frame. Sits between the key debouncer and the Sobel magnitude/compare stage.

---
 rtl/sobel_threshold_ctrl.sv | 147 ++++++++++++++
 tb/tb_sobel_threshold_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_threshold_ctrl.sv
// Purpose : edits a shadow Sobel gradient threshold from debounced key events and
//           commits it to the live threshold only at frame start (rising frame_vsync).
// Latency : key -> shadow/pending 1 cycle; vsync edge -> threshold/th_update 2 cycles.
// Backpr. : none; key_flag strobes are always accepted, frame_vsync is sampled every cycle.
//
// Optional build macro: THRESH_WRAP_EN -- out-of-range steps wrap to the opposite
// bound instead of saturating.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key_flag        one-cycle strobe qualifying key_value
//   key_value       key code: bit0 inc, bit1 dec, bit2 toggle step, bit3 restore default
//   frame_vsync     active-high frame sync, synchronous to clk
//   threshold       committed threshold for the Sobel compare stage
//   th_update       one-cycle pulse when threshold is loaded
//   step_coarse     1 = coarse step selected
//   pending         shadow edited and not yet committed
module sobel_threshold_ctrl #(
  parameter int KEY_WIDTH   = 4,
  parameter int TH_WIDTH    = 8,
  parameter int TH_DEFAULT  = 64,
  parameter int TH_MIN      = 0,
  parameter int TH_MAX      = 255,
  parameter int STEP_FINE   = 1,
  parameter int STEP_COARSE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_flag,
  input  logic [KEY_WIDTH-1:0] key_value,
  input  logic                 frame_vsync,
  output logic [TH_WIDTH-1:0]  threshold,
  output logic                 th_update,
  output logic                 step_coarse,
  output logic                 pending
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Bound checks are done one bit wider than the threshold so that
  // shadow + step can never wrap around before it is compared.
  localparam int AW = TH_WIDTH + 1;
  localparam logic [AW-1:0] MIN_A    = AW'(TH_MIN);
  localparam logic [AW-1:0] MAX_A    = AW'(TH_MAX);
  localparam logic [AW-1:0] FINE_A   = AW'(STEP_FINE);
  localparam logic [AW-1:0] COARSE_A = AW'(STEP_COARSE);

  localparam logic [TH_WIDTH-1:0] DEF_W    = TH_WIDTH'(TH_DEFAULT);
  localparam logic [TH_WIDTH-1:0] MIN_W    = TH_WIDTH'(TH_MIN);
  localparam logic [TH_WIDTH-1:0] MAX_W    = TH_WIDTH'(TH_MAX);
  localparam logic [TH_WIDTH-1:0] FINE_W   = TH_WIDTH'(STEP_FINE);
  localparam logic [TH_WIDTH-1:0] COARSE_W = TH_WIDTH'(STEP_COARSE);

  logic [1:0]          state, state_nxt;
  logic [TH_WIDTH-1:0] shadow, shadow_nxt;
  logic                step_coarse_nxt;
  logic                vsync_r;
  logic                frame_edge;
  logic                edit;
  logic [AW-1:0]       step_a;
  logic [TH_WIDTH-1:0] step_w;
  logic                inc_over;
  logic                dec_under;

  assign frame_edge = frame_vsync & ~vsync_r;

  always_comb begin
    step_a    = step_coarse ? COARSE_A : FINE_A;
    step_w    = step_coarse ? COARSE_W : FINE_W;
    inc_over  = (({1'b0, shadow} + step_a) > MAX_A);
    dec_under = ({1'b0, shadow} < (MIN_A + step_a));
  end

  // Key decode: restore beats toggle beats inc/dec; inc+dec together cancel.
  always_comb begin
    shadow_nxt      = shadow;
    step_coarse_nxt = step_coarse;
    edit            = 1'b0;
    if (key_flag) begin
      if (key_value[3]) begin
        shadow_nxt = DEF_W;
        edit       = 1'b1;
      end else if (key_value[2]) begin
        step_coarse_nxt = ~step_coarse;
      end else if (key_value[0] && !key_value[1]) begin
        edit = 1'b1;
        if (inc_over) begin
`ifdef THRESH_WRAP_EN
          shadow_nxt = MIN_W;
`else
          shadow_nxt = MAX_W;
`endif
        end else begin
          shadow_nxt = shadow + step_w;
        end
      end else if (key_value[1] && !key_value[0]) begin
        edit = 1'b1;
        if (dec_under) begin
`ifdef THRESH_WRAP_EN
          shadow_nxt = MAX_W;
`else
          shadow_nxt = MIN_W;
`endif
        end else begin
          shadow_nxt = shadow - step_w;
        end
      end
    end
  end

  // Commit FSM. An edit landing in the COMMIT cycle is not part of this
  // commit (threshold takes the pre-edit shadow) so it re-arms PEND.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (edit) state_nxt = S_PEND;
      S_PEND:   if (frame_edge) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = edit ? S_PEND : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shadow      <= DEF_W;
      threshold   <= DEF_W;
      step_coarse <= 1'b0;
      th_update   <= 1'b0;
      pending     <= 1'b0;
      vsync_r     <= 1'b1;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      step_coarse <= step_coarse_nxt;
      vsync_r     <= frame_vsync;
      th_update   <= (state == S_COMMIT);
      pending     <= (state_nxt != S_IDLE);
      if (state == S_COMMIT) begin
        threshold <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// Purpose : self-checking bench for sobel_threshold_ctrl (vector table, corner
//           sequences, randomized run against a behavioural model).
// Latency : checks are taken 1 time unit after each rising clock edge.
// Backpr. : not applicable.
module tb_sobel_threshold_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_flag;
  logic [3:0] key_value;
  logic       frame_vsync;
  logic [7:0] threshold;
  logic       th_update;
  logic       step_coarse;
  logic       pending;

  int errors = 0;
  int checks = 0;

  sobel_threshold_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .frame_vsync (frame_vsync),
    .threshold   (threshold),
    .th_update   (th_update),
    .step_coarse (step_coarse),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef THRESH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    bit       rst;
    bit       kf;
    bit [3:0] kv;
    bit       vs;
    int       th;
    bit       upd;
    bit       co;
    bit       pe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit kf, bit [3:0] kv, bit vs,
                              int th, bit upd, bit co, bit pe);
    vec_t v;
    v.rst = rst; v.kf = kf; v.kv = kv; v.vs = vs;
    v.th = th; v.upd = upd; v.co = co; v.pe = pe;
    return v;
  endfunction

  task automatic chk(string nm, int th, bit upd, bit co, bit pe);
    checks++;
    if (int'(threshold) != th) begin
      errors++;
      $display("FAIL %s threshold got %0d want %0d", nm, threshold, th);
    end
    checks++;
    if (th_update !== upd) begin
      errors++;
      $display("FAIL %s th_update got %b want %b", nm, th_update, upd);
    end
    checks++;
    if (step_coarse !== co) begin
      errors++;
      $display("FAIL %s step_coarse got %b want %b", nm, step_coarse, co);
    end
    checks++;
    if (pending !== pe) begin
      errors++;
      $display("FAIL %s pending got %b want %b", nm, pending, pe);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_flag = 1'b0;
    key_value = 4'd0;
    frame_vsync = 1'b0;
    tick();
  endtask

  task automatic press(bit [3:0] kv);
    key_flag = 1'b1;
    key_value = kv;
    tick();
    key_flag = 1'b0;
    key_value = 4'd0;
  endtask

  // Raise vsync for the edge cycle and the commit cycle, then drop it.
  task automatic frame(string nm, int th, bit co);
    frame_vsync = 1'b1;
    tick();
    tick();
    chk(nm, th, 1'b1, co, 1'b0);
    frame_vsync = 1'b0;
    tick();
  endtask

  // Behavioural model: a dirty flag for uncommitted edits and a flag for a
  // commit scheduled in the following cycle.
  int m_sh, m_th;
  bit m_co, m_dirty, m_commit, m_upd, m_vs_prev;

  function automatic void model_reset();
    m_sh = 64; m_th = 64; m_co = 0; m_dirty = 0; m_commit = 0; m_upd = 0;
    m_vs_prev = 1;
  endfunction

  function automatic void model_step(bit kf, bit [3:0] kv, bit vs);
    bit edge_now, commit_now, edit;
    int step;
    edge_now = vs && !m_vs_prev;
    m_vs_prev = vs;
    commit_now = m_commit;
    m_upd = commit_now;
    if (commit_now) m_th = m_sh;
    edit = 0;
    step = m_co ? 16 : 1;
    if (kf) begin
      if (kv[3]) begin
        m_sh = 64; edit = 1;
      end else if (kv[2]) begin
        m_co = !m_co;
      end else if (kv[0] != kv[1]) begin
        edit = 1;
        if (kv[0]) m_sh = (m_sh + step > 255) ? (WRAP ? 0 : 255) : m_sh + step;
        else       m_sh = (m_sh - step < 0)   ? (WRAP ? 255 : 0) : m_sh - step;
      end
    end
    if (commit_now) begin
      m_commit = 0;
      m_dirty = edit;
    end else if (m_dirty && edge_now) begin
      m_commit = 1;
      m_dirty = 0;
    end else begin
      m_dirty = m_dirty || edit;
    end
  endfunction

  initial begin
    int hi, lo;
    rst_n = 1'b0;
    key_flag = 1'b0;
    key_value = 4'd0;
    frame_vsync = 1'b0;

    // rst, kf, kv, vs, th, upd, coarse, pending
    // three increments then a frame edge
    tbl.push_back(mk(1, 0, 4'h0, 0, 64, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h1, 0, 64, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 0, 64, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 0, 64, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 67, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 67, 0, 0, 0));
    // coarse toggle then decrement
    tbl.push_back(mk(1, 0, 4'h0, 0, 64, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h4, 0, 64, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 64, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 48, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 48, 0, 1, 0));
    // inc+dec cancels, restore wins over inc, edges in IDLE do nothing
    tbl.push_back(mk(1, 0, 4'h0, 0, 64, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h3, 0, 64, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 64, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hD, 0, 64, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 64, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 64, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
        chk($sformatf("vec%0d_reset", i), tbl[i].th, tbl[i].upd, tbl[i].co, tbl[i].pe);
        rst_n = 1'b1;
      end else begin
        key_flag = tbl[i].kf;
        key_value = tbl[i].kv;
        frame_vsync = tbl[i].vs;
        tick();
        chk($sformatf("vec%0d", i), tbl[i].th, tbl[i].upd, tbl[i].co, tbl[i].pe);
      end
    end
    key_flag = 1'b0;
    frame_vsync = 1'b0;

    // bound handling at the top and bottom
    hi = WRAP ? 0 : 255;
    lo = WRAP ? 255 : 0;
    do_reset();
    rst_n = 1'b1;
    press(4'h4);
    repeat (11) press(4'h1);
    press(4'h4);
    repeat (10) press(4'h1);
    frame("reach_250", 250, 1'b0);
    press(4'h4);
    press(4'h1);
    frame("inc_bound", hi, 1'b1);
    press(4'h8);
    repeat (4) press(4'h2);
    frame("coarse_to_0", 0, 1'b1);
    press(4'h4);
    press(4'h2);
    frame("dec_bound", lo, 1'b0);

    // edit exactly in the COMMIT cycle
    do_reset();
    rst_n = 1'b1;
    repeat (6) press(4'h1);
    frame_vsync = 1'b1;
    tick();
    chk("cc_edge", 64, 1'b0, 1'b0, 1'b1);
    key_flag = 1'b1;
    key_value = 4'h1;
    tick();
    key_flag = 1'b0;
    key_value = 4'h0;
    chk("cc_commit", 70, 1'b1, 1'b0, 1'b1);
    frame_vsync = 1'b0;
    tick();
    chk("cc_wait", 70, 1'b0, 1'b0, 1'b1);
    frame("cc_next", 71, 1'b0);

    // asynchronous reset while pending
    do_reset();
    rst_n = 1'b1;
    repeat (10) press(4'h1);
    press(4'h4);
    press(4'h1);
    chk("ar_pend", 64, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("ar_async", 64, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    frame_vsync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ar_no_upd%0d", i), 64, 1'b0, 1'b0, 1'b0);
    end
    frame_vsync = 1'b0;

    // randomized run against the model
    do_reset();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      key_flag = ($urandom_range(0, 2) == 0);
      key_value = 4'($urandom);
      if ($urandom_range(0, 15) == 0) frame_vsync = ~frame_vsync;
      model_step(key_flag, key_value, frame_vsync);
      tick();
      chk($sformatf("rand%0d", c), m_th, m_upd, m_co, m_dirty || m_commit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
